bat_amateur_alu: RTL
====================

Name: bat_amateur_alu

Overview:
- 8-bit sequential ALU directly upstream of the microcode controller.
- Produces the ALU_REG status byte that the controller samples into its zero and carry flags.
- Drives computed results toward the data bus under controller command (ALU_EN, ALU_OP).
- Single-cycle ops complete in one clock; unsigned multiply is an 8-cycle shift-add sequence with a BUSY indication.

Parameters:
- WIDTH, 8, operand/result width. Only 8 is supported; the multiplier step count equals WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-low reset.
- A_IN  input  8  operand A (register A contents).
- B_IN  input  8  operand B (register B contents).
- ALU_EN  input  1  start an operation this cycle.
- ALU_OP  input  5  operation select, sampled with ALU_EN.
- BUS_OUT  output  8  registered result; holds the last result.
- RESULT_VALID  output  1  one-cycle pulse when BUS_OUT takes a new result.
- ALU_REG  output  8  status byte:
  - [0] Z
  - [1] C
  - [2] N
  - [3] V
  - [4] BUSY
  - [5] ILL
  - [7:6] always 0

Behaviour:
- Reset: on a rising CLK with RST=0, the block returns to IDLE and the following are all 0: BUS_OUT, RESULT_VALID, ALU_REG, the MUL high-byte latch and the step counter.
- Reset during MUL aborts the multiply; no RESULT_VALID pulse is produced.
- States: IDLE and MUL_RUN.
- Accept rule: an op is accepted on the rising edge where ALU_EN=1 and BUSY=0.
  - ALU_EN while BUSY=1 is ignored entirely; no state or flag change.
- Single-cycle ops: result and flags are registered at the accepting edge, and RESULT_VALID=1 for exactly the following cycle.
- Op codes (hex):
  - 00 PASSA: A
  - 01 PASSB: B
  - 02 ADD: A+B
  - 03 ADC: A+B+C
  - 04 SUB: A-B
  - 05 SBC: A-B-C
  - 06 AND
  - 07 OR
  - 08 XOR
  - 09 NOT A
  - 0A INC A
  - 0B DEC A
  - 0C SHL A (C=A[7])
  - 0D SHR A (C=A[0])
  - 0E ROL A through C
  - 0F ROR A through C
  - 10 CMP: flags of A-B only; BUS_OUT unchanged, no RESULT_VALID
  - 11 MUL: unsigned A*B; BUS_OUT gets the low byte, the high byte is latched
  - 12 MULH: BUS_OUT gets the latched high byte; flags unchanged
- Carry (arithmetic):
  - Add ops: C = carry out of bit 7.
  - Subtract ops: C = borrow, i.e. 1 when the unsigned minuend is less than the subtrahend (plus borrow-in).
  - INC/DEC: C = wrap indicator (INC FF->00 sets C; DEC 00->FF sets C).
- Logic ops (06-09): C=0, V=0.
- Z = (8-bit result == 0). N = result[7].
- V = signed overflow for add/sub/INC/DEC; 0 for all other ops.
- Carry-in for ADC/SBC/ROL/ROR is the C flag value before the op.
- MUL sequence:
  - At the accepting edge: latch A and B, clear the accumulator, enter MUL_RUN, BUSY=1.
  - Run exactly WIDTH (8) shift-add steps, one per cycle.
  - On the 8th step edge: BUS_OUT=product[7:0], high latch=product[15:8], BUSY=0, return to IDLE.
  - RESULT_VALID pulses the cycle after that edge.
  - Flags: Z=(product16==0), C=(product[15:8]!=0), N=0, V=0.
  - Total: ALU_EN edge to RESULT_VALID is 9 cycles. A new op may be accepted in the RESULT_VALID cycle.
- Illegal ops (13-1F):
  - BUS_OUT and Z/C/N/V unchanged.
  - ILL=1, no RESULT_VALID.
- ILL is cleared by the next legal accepted op or by reset.
- Flags persist until the next flag-writing op. ALU_REG is purely registered, with no combinational path from inputs.

Test Plan:
- Reset: drive RST=0 for 2 cycles during a MUL started with A=0xFF, B=0xFF -> ALU_REG=0x00, BUS_OUT=0x00, and no RESULT_VALID pulse afterwards.
- ADD with A=0xFF, B=0x01 -> BUS_OUT=0x00, Z=1, C=1, V=0. Then ADC with A=0x10, B=0x20 -> BUS_OUT=0x31, C=0.
- SUB with A=0x80, B=0x01 -> BUS_OUT=0x7F, V=1, C=0, N=0. Then CMP with A=0x05, B=0x09 -> BUS_OUT stays 0x7F, C=1, N=1, no RESULT_VALID.
- MUL with A=0xC8, B=0x0A:
  - BUSY=1 for 8 cycles, then BUS_OUT=0xD0, C=1, RESULT_VALID at cycle 9.
  - MULH then gives 0x07.
  - ALU_EN with ADD during BUSY is ignored.
- ROL: with C=1 and A=0x81 -> BUS_OUT=0x03, C=1. Then ROR with A=0x02 and C=1 -> BUS_OUT=0x81, C=0.
- Illegal op 0x1F -> ALU_REG[5]=1, other flags unchanged. Next PASSA with A=0x00 -> ILL=0, Z=1.

Source files
------------

// File: rtl/bat_amateur_alu.sv
`default_nettype none
// ============================================================================
// Module   : bat_amateur_alu
// Purpose  : 8-bit sequential ALU feeding the microcode controller. Single
//            cycle arithmetic/logic ops plus an 8-step shift-add multiply.
//            ALU_REG = {2'b00, ILL, BUSY, V, N, C, Z}.
// Revision : 1.0 - initial release
// ============================================================================
module bat_amateur_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             ALU_EN,
  input  logic [4:0]       ALU_OP,
  output logic [WIDTH-1:0] BUS_OUT,
  output logic             RESULT_VALID,
  output logic [7:0]       ALU_REG
);

  localparam logic [4:0] OP_PASSA = 5'h00;
  localparam logic [4:0] OP_PASSB = 5'h01;
  localparam logic [4:0] OP_ADD   = 5'h02;
  localparam logic [4:0] OP_ADC   = 5'h03;
  localparam logic [4:0] OP_SUB   = 5'h04;
  localparam logic [4:0] OP_SBC   = 5'h05;
  localparam logic [4:0] OP_AND   = 5'h06;
  localparam logic [4:0] OP_OR    = 5'h07;
  localparam logic [4:0] OP_XOR   = 5'h08;
  localparam logic [4:0] OP_NOT   = 5'h09;
  localparam logic [4:0] OP_INC   = 5'h0A;
  localparam logic [4:0] OP_DEC   = 5'h0B;
  localparam logic [4:0] OP_SHL   = 5'h0C;
  localparam logic [4:0] OP_SHR   = 5'h0D;
  localparam logic [4:0] OP_ROL   = 5'h0E;
  localparam logic [4:0] OP_ROR   = 5'h0F;
  localparam logic [4:0] OP_CMP   = 5'h10;
  localparam logic [4:0] OP_MUL   = 5'h11;
  localparam logic [4:0] OP_MULH  = 5'h12;

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

  state_t state, state_next;

  logic                 flag_z, flag_c, flag_n, flag_v, flag_ill;
  logic [CNT_W-1:0]     step_cnt;
  logic [2*WIDTH-1:0]   mul_mcand;
  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]     mul_mplier;
  logic [WIDTH-1:0]     mul_hi;

  logic                 busy;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_step_acc;
  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic                 add_cin, sub_cin;

  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v;
  logic                 wr_bus, wr_flags, legal;

  assign busy     = (state == ST_MUL_RUN);
  assign mul_last = busy && (step_cnt == LAST_STEP);

  // Carry/borrow-in only participates for the "with carry" variants.
  assign add_cin  = (ALU_OP == OP_ADC) && flag_c;
  assign sub_cin  = (ALU_OP == OP_SBC) && flag_c;
  assign add_full = {1'b0, A_IN} + {1'b0, B_IN} + {{WIDTH{1'b0}}, add_cin};
  // Bit WIDTH of the 9-bit difference is the borrow out.
  assign sub_full = {1'b0, A_IN} - {1'b0, B_IN} - {{WIDTH{1'b0}}, sub_cin};

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  assign mul_step_acc = mul_acc + (mul_mplier[0] ? mul_mcand : {(2*WIDTH){1'b0}});

  // Status byte is built only from registers.
  assign ALU_REG = {2'b00, flag_ill, busy, flag_v, flag_n, flag_c, flag_z};

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: MUL is the only op that leaves IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (ALU_EN && (ALU_OP == OP_MUL)) state_next = ST_MUL_RUN;
      ST_MUL_RUN: if (mul_last) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Single-cycle result, carry and overflow for the op currently presented.
  always_comb begin
    res      = '0;
    res_c    = flag_c;
    res_v    = 1'b0;
    wr_bus   = 1'b1;
    wr_flags = 1'b1;
    legal    = 1'b1;
    case (ALU_OP)
      OP_PASSA: begin res = A_IN; res_c = 1'b0; end
      OP_PASSB: begin res = B_IN; res_c = 1'b0; end
      OP_ADD, OP_ADC: begin
        res   = add_full[WIDTH-1:0];
        res_c = add_full[WIDTH];
        res_v = (A_IN[WIDTH-1] == B_IN[WIDTH-1]) && (add_full[WIDTH-1] != A_IN[WIDTH-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        res    = sub_full[WIDTH-1:0];
        res_c  = sub_full[WIDTH];
        res_v  = (A_IN[WIDTH-1] != B_IN[WIDTH-1]) && (sub_full[WIDTH-1] != A_IN[WIDTH-1]);
        wr_bus = (ALU_OP != OP_CMP);
      end
      OP_AND: begin res = A_IN & B_IN; res_c = 1'b0; end
      OP_OR:  begin res = A_IN | B_IN; res_c = 1'b0; end
      OP_XOR: begin res = A_IN ^ B_IN; res_c = 1'b0; end
      OP_NOT: begin res = ~A_IN;       res_c = 1'b0; end
      OP_INC: begin
        res   = A_IN + ONE;
        res_c = (A_IN == {WIDTH{1'b1}});
        res_v = (A_IN == MAX_POS);
      end
      OP_DEC: begin
        res   = A_IN - ONE;
        res_c = (A_IN == {WIDTH{1'b0}});
        res_v = (A_IN == MIN_NEG);
      end
      OP_SHL: begin res = {A_IN[WIDTH-2:0], 1'b0};   res_c = A_IN[WIDTH-1]; end
      OP_SHR: begin res = {1'b0, A_IN[WIDTH-1:1]};   res_c = A_IN[0];       end
      OP_ROL: begin res = {A_IN[WIDTH-2:0], flag_c}; res_c = A_IN[WIDTH-1]; end
      OP_ROR: begin res = {flag_c, A_IN[WIDTH-1:1]}; res_c = A_IN[0];       end
      OP_MUL: begin wr_bus = 1'b0; wr_flags = 1'b0; end
      OP_MULH: begin res = mul_hi; wr_flags = 1'b0; end
      default: begin legal = 1'b0; wr_bus = 1'b0; wr_flags = 1'b0; end
    endcase
  end

  // Datapath: accept ops in IDLE, run the multiplier while busy.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      BUS_OUT      <= '0;
      RESULT_VALID <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      flag_n       <= 1'b0;
      flag_v       <= 1'b0;
      flag_ill     <= 1'b0;
      step_cnt     <= '0;
      mul_mcand    <= '0;
      mul_acc      <= '0;
      mul_mplier   <= '0;
      mul_hi       <= '0;
    end else begin
      RESULT_VALID <= 1'b0;
      if (!busy) begin
        if (ALU_EN) begin
          if (legal) begin
            flag_ill <= 1'b0;
            if (ALU_OP == OP_MUL) begin
              mul_mcand  <= {{WIDTH{1'b0}}, A_IN};
              mul_mplier <= B_IN;
              mul_acc    <= '0;
              step_cnt   <= '0;
            end
            if (wr_bus) begin
              BUS_OUT      <= res;
              RESULT_VALID <= 1'b1;
            end
            if (wr_flags) begin
              flag_z <= (res == {WIDTH{1'b0}});
              flag_c <= res_c;
              flag_n <= res[WIDTH-1];
              flag_v <= res_v;
            end
          end else begin
            flag_ill <= 1'b1;
          end
        end
      end else begin
        mul_acc    <= mul_step_acc;
        mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
        mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
        step_cnt   <= step_cnt + CNT_W'(1);
        if (mul_last) begin
          BUS_OUT      <= mul_step_acc[WIDTH-1:0];
          mul_hi       <= mul_step_acc[2*WIDTH-1:WIDTH];
          RESULT_VALID <= 1'b1;
          step_cnt     <= '0;
          flag_z       <= (mul_step_acc == {(2*WIDTH){1'b0}});
          flag_c       <= (mul_step_acc[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          flag_n       <= 1'b0;
          flag_v       <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
